// File: rtl/mul_issue_ctrl_pkg.sv
// mul_issue_ctrl_pkg: shared op/state encodings and widths for the multiplier issue controller
package mul_issue_ctrl_pkg;
    localparam int XLEN = 32;
    localparam int OPW  = 33;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01, OP_MULHSU = 2'b10, OP_MULHU = 2'b11} op_e;
    typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequences one RISC-V multiply through an external 33x33 multiplier, with optional zero bypass
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            mul_Run,
    output logic [OPW-1:0]  mul_A,
    output logic [OPW-1:0]  mul_B,
    input  logic            mul_ready,
    input  logic [OPW-1:0]  mul_Aval,
    input  logic [OPW-1:0]  mul_Bval
);
    state_e          r_state, w_next;
    op_e             r_op, w_op;
    logic [OPW-1:0]  r_a, r_b, w_a, w_b;
    logic [XLEN-1:0] r_data, w_res;
    logic            w_accept, w_byp, w_unused;
    assign w_op     = op_e'(req_op);
    assign w_a      = {(w_op != OP_MULHU) & req_rs1[XLEN-1], req_rs1};
    assign w_b      = {~req_op[1] & req_rs2[XLEN-1], req_rs2};
    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_byp    = ZERO_BYPASS && (req_rs1 == '0 || req_rs2 == '0);
    // product is {mul_Aval, mul_Bval}; the high word is product[63:32]
    assign w_res    = (r_op == OP_MUL) ? mul_Bval[XLEN-1:0] : {mul_Aval[XLEN-2:0], mul_Bval[OPW-1]};
    assign w_unused = ^mul_Aval[OPW-1:XLEN-1];
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = req_valid ? (w_byp ? S_DONE : S_START) : S_IDLE;
            S_START: w_next = S_ARM;
            S_ARM:   w_next = S_WAIT;
            S_WAIT:  w_next = mul_ready ? S_DONE : S_WAIT;
            S_DONE:  w_next = resp_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_MUL;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= w_op;
                r_a    <= w_a;
                r_b    <= w_b;
                r_data <= '0;
            end
            if (r_state == S_WAIT && mul_ready)
                r_data <= w_res;
        end
    end
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign mul_Run    = (r_state == S_START);
    assign resp_valid = (r_state == S_DONE);
    assign resp_data  = r_data;
    assign mul_A      = r_a;
    assign mul_B      = r_b;
endmodule
